// File: rtl/spi_ram.sv
// spi_ram: 256x8 single-port storage behind the SPI slave.
// Decodes 10-bit command words into address loads, writes and reads.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic       tx_valid,
    output logic [7:0] dout
);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [1:0]           op;
    logic [7:0]           payload;
    logic                 cmd_ok;

    assign op      = din[9:8];
    assign payload = din[7:0];
    assign cmd_ok  = rx_valid && !rst_n;

    // Array kept out of the reset block so its contents survive reset.
    always_ff @(posedge clk) begin
        if (cmd_ok && op == OP_WR_DATA)
            mem[wr_addr] <= payload;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (rx_valid) begin
                unique case (1'b1)
                    (op == OP_WR_ADDR): wr_addr <= payload[ADDR_SIZE-1:0];
                    (op == OP_WR_DATA): ;
                    (op == OP_RD_ADDR): rd_addr <= payload[ADDR_SIZE-1:0];
                    (op == OP_RD_DATA): begin
                        dout     <= mem[rd_addr];
                        tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: directed plus random commands against a
// behavioural RAM model.
module tb_spi_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic       tx_valid;
    logic [7:0] dout;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_mem [256];
    logic [7:0] m_wr, m_rd, m_dout;
    logic       m_tx;

    spi_ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .tx_valid (tx_valid),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive on negedge, update model, sample after posedge.
    task automatic step(input logic r, input logic v,
                        input logic [9:0] d);
        @(negedge clk);
        rst_n = r;
        rx_valid = v;
        din = d;
        @(posedge clk);
        #1;
        if (r) begin
            m_wr = 8'h00;
            m_rd = 8'h00;
            m_dout = 8'h00;
            m_tx = 1'b0;
        end else begin
            m_tx = 1'b0;
            if (v) begin
                case (d[9:8])
                    2'b00: m_wr = d[7:0];
                    2'b01: m_mem[m_wr] = d[7:0];
                    2'b10: m_rd = d[7:0];
                    default: begin
                        m_dout = m_mem[m_rd];
                        m_tx = 1'b1;
                    end
                endcase
            end
        end
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_tx});
        chk("dout", {24'd0, dout}, {24'd0, m_dout});
    endtask

    task automatic cmd(input logic [9:0] d);
        step(1'b0, 1'b1, d);
    endtask

    initial begin
        logic [9:0] d;
        int r;

        // Reset with a full read-data command presented.
        step(1'b1, 1'b1, 10'h3FF);
        chk("rst_dout", {24'd0, dout}, 32'h0);
        chk("rst_tx", {31'd0, tx_valid}, 32'h0);

        // Fill the whole array so every later read is defined.
        for (int a = 0; a < 256; a++) begin
            d = {2'b00, 8'(a)};
            cmd(d);
            d = {2'b01, 8'($urandom_range(0, 255))};
            cmd(d);
        end

        // Basic write/read.
        cmd(10'h004);
        cmd(10'h107);
        cmd(10'h204);
        cmd(10'h300);
        chk("basic_rd", {24'd0, dout}, 32'h07);
        chk("basic_tx", {31'd0, tx_valid}, 32'h1);

        // Idle hold with toggling din.
        for (int i = 0; i < 3; i++) begin
            d = 10'($urandom);
            step(1'b0, 1'b0, d);
        end
        chk("idle_dout", {24'd0, dout}, 32'h07);
        chk("idle_tx", {31'd0, tx_valid}, 32'h0);
        cmd(10'h204);
        cmd(10'h300);
        chk("idle_mem", {24'd0, dout}, 32'h07);

        // Boundary address and overwrite.
        cmd(10'h0FF);
        cmd(10'h1AA);
        cmd(10'h155);
        cmd(10'h2FF);
        cmd(10'h300);
        chk("ff_rd", {24'd0, dout}, 32'h55);
        cmd(10'h200);
        cmd(10'h300);

        // Independent pointers.
        cmd(10'h010);
        cmd(10'h211);
        cmd(10'h1CC);
        cmd(10'h300);
        cmd(10'h210);
        cmd(10'h300);
        chk("ptr_rd", {24'd0, dout}, 32'hCC);

        // Back-to-back read-data keeps tx_valid high.
        cmd(10'h300);
        cmd(10'h3A5);

        // Reset between address and data command.
        cmd(10'h020);
        step(1'b1, 1'b0, 10'h000);
        cmd(10'h1EE);
        cmd(10'h200);
        cmd(10'h300);
        chk("rst_mid", {24'd0, dout}, 32'hEE);

        // Write command during reset is dropped.
        step(1'b1, 1'b1, 10'h111);
        cmd(10'h200);
        cmd(10'h300);
        chk("rst_drop", {24'd0, dout}, 32'hEE);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            d = 10'($urandom);
            if (r < 2)
                step(1'b1, 1'($urandom), d);
            else if (r < 15)
                step(1'b0, 1'b0, d);
            else
                cmd(d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
